// File: rtl/pwlen_pkg.sv
// Shared constants and types for the keypad digit-entry tracker.
//   MAX_LEN : maximum digits per word. The count saturates here. It is also the width of the
//             write-select and LED outputs.
//   CNT_W   : width of the digit count. 2**CNT_W must be greater than MAX_LEN.
//   len_t   : the digit-count type.
package pwlen_pkg;

  localparam int unsigned MAX_LEN = 6;
  localparam int unsigned CNT_W   = 3;

  typedef logic [CNT_W-1:0] len_t;

endpackage

// File: rtl/length_decoder.sv
// Combinational decode of the digit count.
//   length_i       : digits entered so far, 0..MAX_LEN.
//   dec_en_i       : decoder enable. When low, every write-select is forced low.
//   cs_o           : one-hot select for the cell that receives the next digit.
//                    All zero when the array is full.
//   password_led_o : thermometer output. Bit i is high when length_i > i.
module length_decoder
  import pwlen_pkg::*;
(
  input  len_t               length_i,
  input  logic               dec_en_i,
  output logic [MAX_LEN-1:0] cs_o,
  output logic [MAX_LEN-1:0] password_led_o
);

  // Selects exist only for 0..MAX_LEN-1.
  // length_i == MAX_LEN therefore leaves every select low.
  always_comb begin
    cs_o           = '0;
    password_led_o = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      cs_o[i]           = dec_en_i && (length_i == len_t'(i));
      password_led_o[i] = (length_i > len_t'(i));
    end
  end

endmodule

// File: rtl/password_led_manager.sv
// Keypad digit-entry tracker. It counts digit key presses (0..MAX_LEN, saturating).
// The count is decoded into a one-hot write-select for the input register array and into a
// thermometer LED bar.
//   clk          : system clock. All state changes on the rising edge.
//   reset        : synchronous, active-high reset.
//   key_pressed  : level input, high while a digit key is held.
//   clear        : synchronous count clear. Takes priority over a press.
//   dec_en       : write-select enable.
//   length       : digits entered so far.
//   cs           : one-hot write-select for the next cell.
//   password_led : thermometer display of the length.
//   full         : high when length == MAX_LEN. This port exists only when
//                  PWLEN_FULL_FLAG_EN is defined.
module password_led_manager
  import pwlen_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               key_pressed,
  input  logic               clear,
  input  logic               dec_en,
  output len_t               length,
  output logic [MAX_LEN-1:0] cs,
  output logic [MAX_LEN-1:0] password_led
`ifdef PWLEN_FULL_FLAG_EN
  ,
  output logic               full
`endif
);

  localparam len_t MaxLen = len_t'(MAX_LEN);

  logic key_q, key_d;
  len_t length_q, length_d;
  logic key_rise;

  assign key_rise = key_pressed && !key_q;

  // key_q tracks the key even during clear.
  // As a result, a key held across the release of clear is not counted.
  always_comb begin
    key_d    = key_pressed;
    length_d = length_q;
    if (clear) begin
      length_d = '0;
    end else if (key_rise && (length_q != MaxLen)) begin
      length_d = length_q + len_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q    <= 1'b0;
      length_q <= '0;
    end else begin
      key_q    <= key_d;
      length_q <= length_d;
    end
  end

  assign length = length_q;

  length_decoder u_length_decoder (
    .length_i       (length_q),
    .dec_en_i       (dec_en),
    .cs_o           (cs),
    .password_led_o (password_led)
  );

`ifdef PWLEN_FULL_FLAG_EN
  assign full = (length_q == MaxLen);
`endif

endmodule

// File: tb/tb_password_led_manager.sv
module tb_password_led_manager;
  import pwlen_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               key_pressed = 1'b0;
  logic               clear = 1'b0;
  logic               dec_en = 1'b1;
  len_t               length;
  logic [MAX_LEN-1:0] cs;
  logic [MAX_LEN-1:0] password_led;
`ifdef PWLEN_FULL_FLAG_EN
  logic               full;
`endif

  password_led_manager dut (
    .clk          (clk),
    .reset        (reset),
    .key_pressed  (key_pressed),
    .clear        (clear),
    .dec_en       (dec_en),
    .length       (length),
    .cs           (cs),
    .password_led (password_led)
`ifdef PWLEN_FULL_FLAG_EN
    ,
    .full         (full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned len;
    logic [5:0]  cs;
    logic [5:0]  led;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  int unsigned m_len = 0;
  logic        m_key = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes the expected post-edge outputs.
  // After the clock edge, it pops the expectation and compares it with the DUT outputs.
  task automatic step(input logic rst, input logic key, input logic clr, input logic den);
    exp_t e;
    @(negedge clk);
    reset = rst; key_pressed = key; clear = clr; dec_en = den;
    if (rst) begin
      m_len = 0;
      m_key = 1'b0;
    end else begin
      if (clr) m_len = 0;
      else if (key && !m_key && m_len < 6) m_len = m_len + 1;
      m_key = key;
    end
    e.len  = m_len;
    e.cs   = (den && m_len < 6) ? (6'b000001 << m_len) : 6'b000000;
    e.led  = 6'((7'd1 << m_len) - 7'd1);
    e.full = (m_len == 6);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("length", 32'(length), 32'(e.len));
    check_val("cs", 32'(cs), 32'(e.cs));
    check_val("led", 32'(password_led), 32'(e.led));
`ifdef PWLEN_FULL_FLAG_EN
    check_val("full", 32'(full), 32'(e.full));
`endif
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Test 1: reset.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("rst_cs_const", 32'(cs), 32'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 2: three separate presses.
    press(3);
    check_val("three_len", 32'(length), 32'd3);
    check_val("three_cs", 32'(cs), 32'h08);
    check_val("three_led", 32'(password_led), 32'h07);

    // Test 3: a key held for 10 cycles counts once.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("hold_len", 32'(length), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 4: saturation.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    press(8);
    check_val("sat_len", 32'(length), 32'd6);
    check_val("sat_cs", 32'(cs), 32'h00);
    check_val("sat_led", 32'(password_led), 32'h3F);

    // Test 5: at length 4, clear and a rising edge arrive in the same cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    press(4);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("clr_edge_len", 32'(length), 32'd0);
    // A key still held when clear releases is not counted.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Clear held high while presses arrive.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Test 6: dec_en gating at length 2.
    press(2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("den0_cs", 32'(cs), 32'h00);
    check_val("den0_led", 32'(password_led), 32'h03);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("den1_cs", 32'(cs), 32'h04);

    // Pseudo-random traffic against the model.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 40) == 0), 1'($urandom), ($urandom_range(0, 12) == 0),
           ($urandom_range(0, 5) != 0));

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
